seven_segment_scanner: RTL and testbench



---
 rtl/seven_segment_scanner.sv | 127 ++++++++++++
 tb/tb_seven_segment_scanner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   val_in is captured into a shadow register on val_valid_in and copied to the
//   active register only at a frame boundary, so a digit never tears mid-frame.
//   Each digit slot starts with GUARD cycles of all anodes off (anti-ghosting).
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous, active-high reset
//   val_in        hex value, nibble k -> digit k (digit 0 = rightmost)
//   val_valid_in  one-cycle load strobe for the shadow register
//   digit_en_in   live per-digit enable (0 = dark)
//   blank_lz_in   1 = blank leading zeros (digit 0 never blanked)
//   cat_out       cathodes, active-low, bit0 = a .. bit6 = g
//   an_out        anodes, active-low, at most one low
//   frame_out     one-cycle pulse on the first cycle of a new frame
module seven_segment_scanner #(
    parameter int COUNT_PERIOD = 100000,
    parameter int GUARD        = 4,
    parameter int NUM_DIGITS   = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic                    val_valid_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    blank_lz_in,
    output logic [6:0]              cat_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out
);
    localparam int CW = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(COUNT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]                cnt_q, cnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]   shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0]   active_q, active_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic [6:0]                   cat_q, cat_d;
    logic                         frame_q, frame_d;
    logic [NUM_DIGITS-1:0]        lz;
    logic                         lit;

    // Segment pattern (1 = segment on), bit0 = a .. bit6 = g.
    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Digit k is a leading zero when it and every more-significant nibble are 0.
    assign lz[0] = 1'b0;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
        assign lz[k] = blank_lz_in && (active_q[NUM_DIGITS-1:k] == '0);
    end

    always_comb begin
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        active_d = active_q;
        shadow_d = val_valid_in ? val_in : shadow_q;
        frame_d  = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                // Transfer uses the pre-update shadow; a same-cycle load waits a frame.
                idx_d    = '0;
                active_d = shadow_q;
                frame_d  = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        lit   = (cnt_q >= CNT_GUARD) && digit_en_in[idx_q] && !lz[idx_q];
        an_d  = '1;
        cat_d = 7'h7F;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            cat_d       = ~glyph(active_q[idx_q]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            an_q     <= '1;
            cat_q    <= 7'h7F;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            an_q     <= an_d;
            cat_q    <= cat_d;
            frame_q  <= frame_d;
        end
    end

    assign an_out    = an_q;
    assign cat_out   = cat_q;
    assign frame_out = frame_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with COUNT_PERIOD=8, GUARD=2,
// NUM_DIGITS=8. Outputs are sampled on the falling edge. m counts rising edges
// since reset release; the outputs seen after edge m describe slot position
// (m-1)%8 of digit ((m-1)/8)%8, and frame_out is high when m%64 == 0.
module tb_seven_segment_scanner;
    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] val_in = '0;
    logic        val_valid_in = 1'b0;
    logic [7:0]  digit_en_in = 8'hFF;
    logic        blank_lz_in = 1'b0;
    logic [6:0]  cat_out;
    logic [7:0]  an_out;
    logic        frame_out;

    int checks = 0;
    int errors = 0;
    int m = 0;

    seven_segment_scanner #(.COUNT_PERIOD(8), .GUARD(2), .NUM_DIGITS(8)) dut (
        .clk_in(clk), .rst_in(rst_in), .val_in(val_in), .val_valid_in(val_valid_in),
        .digit_en_in(digit_en_in), .blank_lz_in(blank_lz_in),
        .cat_out(cat_out), .an_out(an_out), .frame_out(frame_out)
    );

    always #5 clk = ~clk;

    // One clock; per-cycle invariants: single anode, guard cycles dark, frame cadence.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rst_in) begin
            m = 0;
        end else begin
            m++;
            checks++;
            assert (($countones(~an_out) <= 1) === 1'b1) else begin
                errors++;
                $error("FAIL onehot m=%0d: observed an=%h, expected at most one low", m, an_out);
            end
            if (((m - 1) % 8) < 2) begin
                checks++;
                assert (an_out === 8'hFF) else begin
                    errors++;
                    $error("FAIL guard m=%0d: observed an=%h, expected ff", m, an_out);
                end
            end
            checks++;
            assert (frame_out === ((m % 64) == 0)) else begin
                errors++;
                $error("FAIL frame m=%0d: observed %b, expected %b", m, frame_out, (m % 64) == 0);
            end
        end
    endtask

    task automatic run_to(input int t);
        while (m < t) tick();
    endtask

    task automatic load(input logic [31:0] v);
        val_in = v;
        val_valid_in = 1'b1;
        tick();
        val_valid_in = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] ea, input logic [6:0] ec, input logic ef);
        checks++;
        assert ({an_out, cat_out, frame_out} === {ea, ec, ef}) else begin
            errors++;
            $error("FAIL %s m=%0d: observed an=%h cat=%h fr=%b, expected an=%h cat=%h fr=%b",
                   tag, m, an_out, cat_out, frame_out, ea, ec, ef);
        end
    endtask

    // Cathodes for 0123_4567, digit 0..7
    logic [6:0] cat1 [0:7] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

    initial begin
        logic [7:0] ea;
        // Reset
        tick(); tick();
        chk("reset", 8'hFF, 7'h7F, 1'b0);

        // Release and load 0123_4567 on the first cycle
        rst_in = 1'b0;
        load(32'h0123_4567);
        chk("first_cycle", 8'hFF, 7'h7F, 1'b0);
        run_to(2);  chk("f0_guard", 8'hFF, 7'h7F, 1'b0);
        run_to(3);  chk("f0_d0_first_lit", 8'hFE, 7'h40, 1'b0);
        run_to(8);  chk("f0_d0_last_lit", 8'hFE, 7'h40, 1'b0);
        run_to(9);  chk("f0_d1_guard", 8'hFF, 7'h7F, 1'b0);
        run_to(11); chk("f0_d1_lit", 8'hFD, 7'h40, 1'b0);
        run_to(64); chk("f0_end_frame", 8'h7F, 7'h40, 1'b1);
        run_to(65); chk("f1_start", 8'hFF, 7'h7F, 1'b0);

        // Frame 1 shows 0123_4567, 6 lit cycles per slot
        for (int k = 0; k < 8; k++) begin
            ea = ~(8'd1 << k);
            run_to(64 + 8*k + 3); chk("f1_slot_first", ea, cat1[k], 1'b0);
            run_to(64 + 8*k + 8); chk("f1_slot_last", ea, cat1[k], k == 7);
        end

        // DEAD_BEEF loaded mid-frame 2: frame 2 keeps old value
        run_to(150); load(32'hDEAD_BEEF);
        run_to(187); chk("f2_d7_old", 8'h7F, 7'h40, 1'b0);
        run_to(195); chk("f3_d0_F", 8'hFE, 7'h0E, 1'b0);
        run_to(251); chk("f3_d7_d", 8'h7F, 7'h21, 1'b0);

        // Leading-zero blanking, 0000_00A0
        run_to(200); load(32'h0000_00A0);
        run_to(256); blank_lz_in = 1'b1;
        run_to(259); chk("lz_d0_0", 8'hFE, 7'h40, 1'b0);
        run_to(267); chk("lz_d1_A", 8'hFD, 7'h08, 1'b0);
        run_to(275); chk("lz_d2_dark", 8'hFF, 7'h7F, 1'b0);
        run_to(315); chk("lz_d7_dark", 8'hFF, 7'h7F, 1'b0);

        // Value 0 with blanking: only digit 0 lit
        run_to(280); load(32'h0);
        run_to(323); chk("lz0_d0", 8'hFE, 7'h40, 1'b0);
        run_to(331); chk("lz0_d1_dark", 8'hFF, 7'h7F, 1'b0);
        run_to(363); chk("lz0_d5_dark", 8'hFF, 7'h7F, 1'b0);

        // Digit enables 1010_0101 with 89AB_CDEF
        run_to(330); load(32'h89AB_CDEF);
        run_to(384); digit_en_in = 8'b1010_0101; blank_lz_in = 1'b0;
        run_to(387); chk("en_d0", 8'hFE, 7'h0E, 1'b0);
        run_to(395); chk("en_d1_off", 8'hFF, 7'h7F, 1'b0);
        run_to(403); chk("en_d2", 8'hFB, 7'h21, 1'b0);
        run_to(411); chk("en_d3_off", 8'hFF, 7'h7F, 1'b0);
        run_to(419); chk("en_d4_off", 8'hFF, 7'h7F, 1'b0);
        run_to(427); chk("en_d5", 8'hDF, 7'h08, 1'b0);
        run_to(435); chk("en_d6_off", 8'hFF, 7'h7F, 1'b0);
        run_to(443); chk("en_d7", 8'h7F, 7'h00, 1'b0);
        run_to(448); chk("en_frame", 8'h7F, 7'h00, 1'b1);
        digit_en_in = 8'hFF;

        // Load on the same edge as the frame transfer
        run_to(460); load(32'h1357_9BDF);
        run_to(507); chk("f7_d7_old", 8'h7F, 7'h00, 1'b0);
        run_to(511); load(32'h2468_ACE0);
        run_to(515); chk("f8_d0_prev_shadow", 8'hFE, 7'h0E, 1'b0);
        run_to(571); chk("f8_d7_prev_shadow", 8'h7F, 7'h79, 1'b0);
        run_to(579); chk("f9_d0_new", 8'hFE, 7'h40, 1'b0);
        run_to(635); chk("f9_d7_new", 8'h7F, 7'h24, 1'b0);

        // Reset mid-frame: shadow (2468_ACE0) discarded
        run_to(650);
        rst_in = 1'b1;
        tick();
        chk("midrst", 8'hFF, 7'h7F, 1'b0);
        rst_in = 1'b0;
        tick();     chk("rel_c1", 8'hFF, 7'h7F, 1'b0);
        run_to(2);  chk("rel_c2", 8'hFF, 7'h7F, 1'b0);
        run_to(3);  chk("rel_d0", 8'hFE, 7'h40, 1'b0);
        run_to(64); chk("rel_frame", 8'h7F, 7'h40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
